// File: rtl/proto_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encodings
// and the HALT opcode.
package proto_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALTED = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without an acknowledge and flags the
// cycle on which the allowed budget is used up.
module fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // Expires during the last allowed cycle so the FSM leaves FETCH right after it.
  assign expired = tick && (count == CW'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/update sequencer: fetches a word, hands it to the
// datapath, then strobes the PC either to increment or to load a branch target.
module instr_sequencer
  import proto_pkg::*;
#(
  parameter int IW            = 16,
  parameter int AW            = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt_req,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          exec_start,
  input  logic          exec_done,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          pc_en,
  output logic          pc_overwrite,
  output logic [AW-1:0] pc_o_data,
  output logic [IW-1:0] ir,
  output logic [15:0]   retired,
  output logic [2:0]    state,
  output logic          fault
);

  state_t state_q, next_state;
  logic   br_taken_q;
  logic   halt_flag;
  logic   exec_first;
  logic   wd_expired;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_FETCH),
    .tick    ((state_q == ST_FETCH) && !imem_ack),
    .expired (wd_expired)
  );

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_IDLE:   if (run) next_state = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)        next_state = ST_DECODE;
        else if (wd_expired) next_state = ST_FAULT;
      end
      ST_DECODE: begin
        if (ir[IW-1:IW-4] == HALT_OPCODE) next_state = ST_HALTED;
        else                              next_state = ST_EXEC;
      end
      ST_EXEC:   if (exec_done) next_state = ST_UPDATE;
      // A halt request arriving in the UPDATE cycle itself still stops here.
      ST_UPDATE: next_state = (halt_flag || halt_req) ? ST_IDLE : ST_FETCH;
      ST_HALTED: next_state = ST_HALTED;
      ST_FAULT:  next_state = ST_FAULT;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ir         <= '0;
      retired    <= '0;
      pc_o_data  <= '0;
      br_taken_q <= 1'b0;
      halt_flag  <= 1'b0;
      exec_first <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= next_state;
      exec_first <= (state_q == ST_DECODE) && (next_state == ST_EXEC);
      fault      <= (next_state == ST_FAULT);
      if (state_q == ST_FETCH && imem_ack) ir <= imem_rdata;
      if (state_q == ST_EXEC && exec_done) begin
        br_taken_q <= branch_taken;
        pc_o_data  <= branch_target;
      end
      if (state_q == ST_UPDATE) retired <= retired + 16'd1;
      if (state_q == ST_UPDATE) begin
        halt_flag <= 1'b0;
      end else if (halt_req && state_q != ST_IDLE &&
                   state_q != ST_HALTED && state_q != ST_FAULT) begin
        halt_flag <= 1'b1;
      end
    end
  end

  // Strobes come purely from registered state so they never glitch on inputs.
  assign imem_req     = (state_q == ST_FETCH);
  assign exec_start   = (state_q == ST_EXEC) && exec_first;
  assign pc_en        = (state_q == ST_UPDATE) && !br_taken_q;
  assign pc_overwrite = (state_q == ST_UPDATE) &&  br_taken_q;
  assign state        = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: walks each scenario cycle by cycle
// with hand-computed expectations.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        pc_en;
  logic        pc_overwrite;
  logic [7:0]  pc_o_data;
  logic [15:0] ir;
  logic [15:0] retired;
  logic [2:0]  state;
  logic        fault;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_UPDATE = 3'd4, S_HALTED = 3'd5,
                         S_FAULT = 3'd6;

  int tests_run = 0;
  int tests_failed = 0;
  int pc_en_cnt, ovw_cnt, start_cnt, excl_viol;

  instr_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .halt_req      (halt_req),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .exec_start    (exec_start),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_en         (pc_en),
    .pc_overwrite  (pc_overwrite),
    .pc_o_data     (pc_o_data),
    .ir            (ir),
    .retired       (retired),
    .state         (state),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pc_en)                 pc_en_cnt++;
    if (pc_overwrite)          ovw_cnt++;
    if (exec_start)            start_cnt++;
    if (pc_en && pc_overwrite) excl_viol++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCounts();
    pc_en_cnt = 0;
    ovw_cnt   = 0;
    start_cnt = 0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    advance(2);
    rst = 1'b0;
  endtask

  // From FETCH: deliver one instruction word, ending in DECODE.
  task automatic applyStimulus(input logic [15:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    advance(1);
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 0; halt_req = 0; imem_ack = 0; imem_rdata = '0;
    exec_done = 0; branch_taken = 0; branch_target = '0;
    excl_viol = 0;
    clearCounts();

    // Reset state
    applyReset();
    checkOutput("rst_state", state, S_IDLE);
    checkOutput("rst_ir", ir, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_strobes", {imem_req, exec_start, pc_en, pc_overwrite}, 0);
    advance(2);
    checkOutput("idle_hold", state, S_IDLE);

    // Sequential fetch: ack 2 cycles after req, done 3 cycles after start
    clearCounts();
    run = 1; advance(1); run = 0;
    checkOutput("seq_fetch", state, S_FETCH);
    checkOutput("seq_imem_req", imem_req, 1);
    exec_done = 1; advance(2); exec_done = 0;
    checkOutput("seq_fetch_wait", state, S_FETCH);
    applyStimulus(16'h1234);
    checkOutput("seq_decode", state, S_DECODE);
    checkOutput("seq_ir", ir, 16'h1234);
    advance(1);
    checkOutput("seq_exec_start", {state, exec_start}, {S_EXEC, 1'b1});
    advance(1);
    checkOutput("seq_exec_start_once", exec_start, 0);
    advance(2);
    exec_done = 1; branch_taken = 0;
    advance(1); exec_done = 0;
    checkOutput("seq_update", {state, pc_en, pc_overwrite}, {S_UPDATE, 2'b10});
    advance(1);
    checkOutput("seq_back_fetch", state, S_FETCH);
    checkOutput("seq_retired", retired, 1);
    checkOutput("seq_pc_en_pulses", pc_en_cnt, 1);
    checkOutput("seq_start_pulses", start_cnt, 1);

    // Branch to 8'hA5
    clearCounts();
    applyStimulus(16'h2345);
    advance(1);
    exec_done = 1; branch_taken = 1; branch_target = 8'hA5;
    advance(1);
    exec_done = 0; branch_taken = 0; branch_target = 8'h00;
    checkOutput("br_update", {state, pc_en, pc_overwrite}, {S_UPDATE, 2'b01});
    checkOutput("br_target", pc_o_data, 8'hA5);
    advance(1);
    checkOutput("br_back_fetch", {state, pc_overwrite}, {S_FETCH, 1'b0});
    checkOutput("br_retired", retired, 2);
    checkOutput("br_ovw_pulses", ovw_cnt, 1);
    checkOutput("br_pc_en_pulses", pc_en_cnt, 0);

    // HALT opcode
    clearCounts();
    applyStimulus(16'hF000);
    checkOutput("halt_decode", state, S_DECODE);
    advance(1);
    checkOutput("halt_state", state, S_HALTED);
    run = 1; exec_done = 1; advance(3); run = 0; exec_done = 0;
    checkOutput("halt_sticky", state, S_HALTED);
    checkOutput("halt_retired", retired, 2);
    checkOutput("halt_no_pulses", {start_cnt[7:0], pc_en_cnt[7:0], ovw_cnt[7:0]}, 0);

    // Fetch timeout: 15 FETCH cycles without ack
    applyReset();
    run = 1; advance(1); run = 0;
    advance(14);
    checkOutput("to_last_fetch", {state, fault}, {S_FETCH, 1'b0});
    advance(1);
    checkOutput("to_fault", {state, fault}, {S_FAULT, 1'b1});
    run = 1; advance(2); run = 0;
    checkOutput("to_fault_sticky", state, S_FAULT);
    applyReset();
    checkOutput("to_reset", {state, fault}, {S_IDLE, 1'b0});

    // halt_req during EXEC
    clearCounts();
    run = 1; advance(1); run = 0;
    applyStimulus(16'h0042);
    advance(1);
    halt_req = 1; advance(1); halt_req = 0;
    exec_done = 1; advance(1); exec_done = 0;
    checkOutput("hr_update_pc_en", {state, pc_en}, {S_UPDATE, 1'b1});
    advance(1);
    checkOutput("hr_idle", state, S_IDLE);
    checkOutput("hr_retired", retired, 1);
    advance(2);
    checkOutput("hr_idle_hold", state, S_IDLE);
    run = 1; advance(1); run = 0;
    checkOutput("hr_resume", state, S_FETCH);

    // Reset during EXEC with exec_done high
    applyStimulus(16'h0777);
    advance(1);
    checkOutput("rx_in_exec", state, S_EXEC);
    clearCounts();
    rst = 1; exec_done = 1; branch_taken = 1; branch_target = 8'h3C;
    advance(1);
    rst = 0; exec_done = 0; branch_taken = 0; branch_target = '0;
    checkOutput("rx_state", state, S_IDLE);
    checkOutput("rx_retired", retired, 0);
    checkOutput("rx_pc_o_data", pc_o_data, 0);
    advance(2);
    checkOutput("rx_no_pulses", {pc_en_cnt[7:0], ovw_cnt[7:0]}, 0);
    checkOutput("excl_violations", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter IW, default 16, instruction word width.
REQ-002 SHALL have parameter AW, default 8, program address width; this matches the program counter.
REQ-003 SHALL have parameter FETCH_TIMEOUT, default 15, the maximum number of FETCH cycles allowed without imem_ack.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start execution from IDLE.
- halt_req  in  1  request to stop after the current instruction.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  IW  fetched instruction.
- exec_start  out  1  one-cycle pulse to the datapath.
- exec_done  in  1  datapath finished the instruction.
- branch_taken  in  1  redirect the PC; qualified by exec_done.
- branch_target  in  AW  redirect address; qualified by exec_done.
- pc_en  out  1  PC increment strobe.
- pc_overwrite  out  1  PC load strobe.
- pc_o_data  out  AW  PC load value.
- ir  out  IW  instruction register.
- retired  out  16  retired-instruction count.
- state  out  3  current state, for debug.
- fault  out  1  fetch timeout occurred.

Function
REQ-005 SHALL implement an FSM with states IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED and FAULT.
REQ-006 IDLE SHALL move to FETCH on the cycle after run=1 is sampled; otherwise it SHALL remain in IDLE.
REQ-007 FETCH SHALL drive imem_req=1 for every cycle spent in FETCH.
REQ-008 In FETCH, when imem_ack=1 the block SHALL capture imem_rdata into ir and move to DECODE.
REQ-009 The FETCH wait counter SHALL clear on entry to FETCH.
REQ-010 If FETCH_TIMEOUT consecutive FETCH cycles pass without imem_ack, the block SHALL move to FAULT.
REQ-011 In DECODE, if ir[IW-1:IW-4]==4'hF (HALT opcode), the block SHALL move to HALTED without asserting exec_start.
REQ-012 In DECODE, for any other opcode, the block SHALL move to EXEC and assert exec_start for exactly the first EXEC cycle.
REQ-013 In EXEC, on exec_done=1 the block SHALL latch branch_taken and branch_target, then move to UPDATE.
REQ-014 exec_done SHALL be ignored in every state other than EXEC.
REQ-015 UPDATE SHALL last one cycle.
REQ-016 In UPDATE, when the latched branch_taken=1, the block SHALL assert pc_overwrite=1 and drive pc_o_data with the latched target; pc_en SHALL be 0.
REQ-017 In UPDATE, when the latched branch_taken=0, the block SHALL assert pc_en=1 and hold pc_overwrite=0.
REQ-018 pc_en and pc_overwrite SHALL never both be 1, and SHALL be 0 outside UPDATE.
REQ-019 retired SHALL increment by 1 in UPDATE, wrapping from 16'hFFFF to 0.
REQ-020 halt_req SHALL set a sticky flag in any state except IDLE, HALTED and FAULT.
REQ-021 At the end of UPDATE, the next state SHALL be IDLE if the halt flag is set (the flag clears), otherwise FETCH.
REQ-022 The HALT instruction SHALL NOT advance the PC and SHALL NOT increment retired.
REQ-023 HALTED and FAULT SHALL be exited only by rst; run SHALL be ignored in both.
REQ-024 fault SHALL be 1 only while in FAULT.
REQ-025 All outputs SHALL be registered, except exec_start, pc_en, pc_overwrite and imem_req, which SHALL be decoded from state only and never from inputs.

Reset
REQ-026 rst SHALL force: state=IDLE, ir=0, retired=0, pc_o_data=0, all strobes=0, fault=0, halt flag=0, timeout counter=0.
REQ-027 rst asserted mid-FETCH or mid-EXEC SHALL abandon the operation with no pc_en or pc_overwrite pulse; reset has priority over all inputs.

Structure
REQ-028 The state enum, the HALT opcode constant 4'hF and the state encodings SHALL live in the shared package proto_pkg.
REQ-029 The fetch timeout SHALL be a sub-module, fetch_watchdog, with ports clk, rst, clear, tick and expired, parameterised by FETCH_TIMEOUT.

Verification
REQ-030 Sequential fetch scenario: rst, then run=1; imem_ack 2 cycles after imem_req with word 16'h1234; exec_done 3 cycles after exec_start with branch_taken=0. Required: ir=16'h1234, exactly one pc_en pulse, retired=1, back in FETCH.
REQ-031 Branch scenario: exec_done with branch_taken=1 and branch_target=8'hA5. Required: one-cycle pc_overwrite with pc_o_data=8'hA5, pc_en=0 throughout.
REQ-032 HALT scenario: fetched word 16'hF000. Required: DECODE goes to HALTED, no exec_start, no PC strobe, retired unchanged; a later run=1 has no effect.
REQ-033 Timeout scenario: hold imem_ack=0 for 15 FETCH cycles. Required: FAULT and fault=1; rst returns the block to IDLE with fault=0.
REQ-034 halt_req scenario: pulse halt_req during EXEC. Required: UPDATE still issues pc_en, then the state is IDLE; the next run=1 resumes fetching.
REQ-035 Reset-in-EXEC scenario: assert rst during EXEC while exec_done=1. Required: no pc_en or pc_overwrite, retired=0, state=IDLE.
